// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Boot-time writer for the instruction memory. It receives a byte stream from
// a host bridge (UART/JTAG) and writes big-endian 32-bit instruction words to
// consecutive word addresses. The CPU core is held in reset until a complete
// program has been written.
//
// Stream layout: 2-byte word count N (high byte first), then 4*N data bytes.
// The first byte of each word lands in bits [31:24].
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous, active-high reset
//   start      single-cycle pulse that begins a new load (ignored while busy)
//   in_data    stream byte
//   in_valid   in_data is valid
//   in_ready   loader accepts a byte this cycle
//   mem_we     instruction memory write enable (one cycle per word)
//   mem_addr   instruction memory word address
//   mem_wdata  instruction word to write
//   cpu_reset  hold the CPU core in reset
//   busy       load in progress
//   done       sticky, last load completed successfully
//   error      sticky, last load aborted (bad length or timeout)
//   word_count words written in the current/last load
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count
);

  // Counter only needs to hold TIMEOUT-1; TIMEOUT >= 2 keeps this >= 1 bit.
  localparam int                TMO_W     = $clog2(TIMEOUT);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);
  localparam logic [32:0]       MAX_WORDS = 33'd1 << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERROR
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [23:0]       shift_q, shift_d;      // first three bytes of the word
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [ADDR_W:0]   count_q, count_d;

  logic in_ready_q, mem_we_q, cpu_reset_q, busy_q, done_q, error_q;

  logic              accept;
  logic [15:0]       len_new;
  logic [ADDR_W:0]   count_inc;

  assign accept    = in_valid && in_ready_q;
  assign len_new   = {len_q[15:8], in_data};
  assign count_inc = count_q + (ADDR_W + 1)'(1);

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    shift_d    = shift_q;
    byte_idx_d = byte_idx_q;
    tmo_d      = tmo_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    count_d    = count_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d = S_LEN_HI;
          tmo_d   = '0;
          count_d = '0;
          addr_d  = '0;
        end
      end

      S_LEN_HI: begin
        if (accept) begin
          len_d[15:8] = in_data;
          state_d     = S_LEN_LO;
        end
      end

      S_LEN_LO: begin
        if (accept) begin
          len_d = len_new;
          if (len_new == 16'd0) begin
            state_d = S_DONE;
          end else if (33'(len_new) > MAX_WORDS) begin
            state_d = S_ERROR;
          end else begin
            state_d    = S_DATA;
            byte_idx_d = 2'd0;
          end
        end
      end

      S_DATA: begin
        if (accept) begin
          shift_d    = {shift_q[15:0], in_data};
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            wdata_d = {shift_q, in_data};
            state_d = S_WRITE;
          end
        end
      end

      S_WRITE: begin
        count_d = count_inc;
        if (33'(count_inc) == 33'(len_q)) begin
          // Address stays on the last word so it never wraps past the top.
          state_d = S_DONE;
        end else begin
          state_d = S_DATA;
          addr_d  = addr_q + ADDR_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Idle watchdog: runs in every byte-receiving state; WRITE never counts.
    // On expiry the partial word is simply abandoned, so no write is issued.
    if (state_q == S_LEN_HI || state_q == S_LEN_LO || state_q == S_DATA) begin
      if (accept) begin
        tmo_d = '0;
      end else if (tmo_q == TMO_LAST) begin
        state_d = S_ERROR;
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      shift_q    <= '0;
      byte_idx_q <= '0;
      tmo_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      shift_q    <= shift_d;
      byte_idx_q <= byte_idx_d;
      tmo_q      <= tmo_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      count_q    <= count_d;
    end
  end

  // Status outputs are decoded from the next state so they are registered
  // yet line up exactly with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      cpu_reset_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      in_ready_q  <= (state_d == S_LEN_HI) || (state_d == S_LEN_LO) ||
                     (state_d == S_DATA);
      mem_we_q    <= (state_d == S_WRITE);
      cpu_reset_q <= (state_d != S_DONE);
      busy_q      <= (state_d == S_LEN_HI) || (state_d == S_LEN_LO) ||
                     (state_d == S_DATA)   || (state_d == S_WRITE);
      done_q      <= (state_d == S_DONE);
      error_q     <= (state_d == S_ERROR);
    end
  end

  assign in_ready   = in_ready_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign cpu_reset  = cpu_reset_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign word_count = count_q;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  localparam int AW  = 4;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          cpu_reset;
  logic          busy;
  logic          done;
  logic          error;
  logic [AW:0]   word_count;

  imem_loader #(.ADDR_W(AW), .TIMEOUT(TMO)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_reset  (cpu_reset),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural model (stream level) ----------------
  // mode: 0 idle, 1 loading, 2 done, 3 error
  int          m_mode  = 0;
  int          m_b     = 0;   // bytes accepted in this load
  int          m_n     = 0;   // declared word count
  int          m_idle  = 0;   // consecutive idle loading cycles
  int          m_wc    = 0;
  int          m_addr  = 0;
  bit          m_wpend = 0;   // a write cycle is expected
  logic [31:0] m_word  = '0;
  logic [31:0] m_wdata = '0;
  bit          chk_en  = 0;

  logic [AW-1:0] log_addr[$];
  logic [31:0]   log_data[$];

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready",   in_ready,   (m_mode == 1) && !m_wpend);
      chk("mem_we",     mem_we,     m_wpend);
      chk("busy",       busy,       m_mode == 1);
      chk("cpu_reset",  cpu_reset,  m_mode != 2);
      chk("done",       done,       m_mode == 2);
      chk("error",      error,      m_mode == 3);
      chk("word_count", word_count, m_wc);
      if (m_wpend) begin
        chk("mem_addr",  mem_addr,  m_addr);
        chk("mem_wdata", mem_wdata, m_wdata);
      end
    end
    if (mem_we === 1'b1) begin
      log_addr.push_back(mem_addr);
      log_data.push_back(mem_wdata);
      $display("write: addr=%0d data=0x%08h", mem_addr, mem_wdata);
    end
    // predict the effect of the coming rising edge
    if (reset) begin
      m_mode = 0; m_wpend = 0; m_wc = 0; m_addr = 0; m_wdata = '0;
    end else if (m_mode != 1) begin
      if (start) begin
        m_mode = 1; m_b = 0; m_idle = 0; m_wc = 0; m_addr = 0; m_wpend = 0;
      end
    end else if (m_wpend) begin
      m_wpend = 0;
      m_wc++;
      if (m_wc == m_n) m_mode = 2;
      else m_addr++;
    end else if (in_valid) begin
      m_b++;
      m_idle = 0;
      if (m_b == 1) begin
        m_n = int'(in_data) * 256;
      end else if (m_b == 2) begin
        m_n = m_n + int'(in_data);
        if (m_n == 0) m_mode = 2;
        else if (m_n > (1 << AW)) m_mode = 3;
      end else begin
        m_word = {m_word[23:0], in_data};
        if ((m_b - 2) % 4 == 0) begin
          m_wpend = 1;
          m_wdata = m_word;
        end
      end
    end else begin
      m_idle++;
      if (m_idle == TMO) m_mode = 3;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Offer one byte after 'gap' idle cycles; in_valid stays high on return.
  task automatic send(input logic [7:0] b, input int gap);
    int cyc;
    bit acc;
    if (gap > 0) begin
      in_valid = 1'b0;
      tick(gap);
    end
    in_data  = b;
    in_valid = 1'b1;
    cyc = 0;
    acc = 0;
    do begin
      acc = in_ready;
      tick(1);
      cyc++;
    end while (!acc && cyc < 40);
    chk("byte_accepted", acc, 1'b1);
  endtask

  task automatic start_load();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
  endtask

  task automatic check_write(input int i, input logic [AW-1:0] a, input logic [31:0] d);
    logic [AW-1:0] ga;
    logic [31:0]   gd;
    ga = (log_addr.size() > i) ? log_addr[i] : {AW{1'b1}};
    gd = (log_data.size() > i) ? log_data[i] : 32'hDEADDEAD;
    chk($sformatf("write%0d_addr", i), ga, a);
    chk($sformatf("write%0d_data", i), gd, d);
  endtask

  logic [7:0] prog [10] = '{8'h00, 8'h02, 8'h24, 8'h08, 8'h00, 8'h05,
                            8'h8C, 8'h09, 8'h00, 8'h04};
  int         gaps [10] = '{0, 3, 1, 0, 5, 2, 0, 0, 7, 1};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required $finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] wv;

    // reset for three cycles
    @(posedge clk);
    #1 chk_en = 1;
    tick(2);
    chk("rst_in_ready",   in_ready,   1'b0);
    chk("rst_mem_we",     mem_we,     1'b0);
    chk("rst_cpu_reset",  cpu_reset,  1'b1);
    chk("rst_busy",       busy,       1'b0);
    chk("rst_done",       done,       1'b0);
    chk("rst_error",      error,      1'b0);
    chk("rst_word_count", word_count, 0);
    chk("rst_mem_addr",   mem_addr,   0);
    chk("rst_mem_wdata",  mem_wdata,  0);
    reset = 1'b0;
    tick(2);

    // two-word program, in_valid held high
    clear_log();
    start_load();
    for (int i = 0; i < 10; i++) send(prog[i], 0);
    in_valid = 1'b0;
    tick(2);
    chk("p1_nwrites", log_addr.size(), 2);
    check_write(0, 4'd0, 32'h24080005);
    check_write(1, 4'd1, 32'h8C090004);
    chk("p1_done", done, 1'b1);
    chk("p1_cpu_reset", cpu_reset, 1'b0);
    chk("p1_word_count", word_count, 2);
    chk("p1_busy", busy, 1'b0);
    $display("txn: two-word load complete");

    // empty program
    clear_log();
    start_load();
    send(8'h00, 0);
    send(8'h00, 0);
    in_valid = 1'b0;
    chk("p0_done", done, 1'b1);
    chk("p0_word_count", word_count, 0);
    chk("p0_cpu_reset", cpu_reset, 1'b0);
    tick(2);
    chk("p0_nwrites", log_addr.size(), 0);
    $display("txn: empty load complete");

    // same program with gaps on in_valid
    clear_log();
    start_load();
    for (int i = 0; i < 10; i++) send(prog[i], gaps[i]);
    in_valid = 1'b0;
    tick(2);
    chk("pg_nwrites", log_addr.size(), 2);
    check_write(0, 4'd0, 32'h24080005);
    check_write(1, 4'd1, 32'h8C090004);
    chk("pg_done", done, 1'b1);
    chk("pg_word_count", word_count, 2);
    $display("txn: gapped two-word load complete");

    // timeout inside a word
    clear_log();
    start_load();
    send(8'h00, 0);
    send(8'h01, 0);
    send(8'h24, 0);
    in_valid = 1'b0;
    tick(TMO - 1);
    chk("tmo_early_error", error, 1'b0);
    tick(1);
    chk("tmo_error", error, 1'b1);
    chk("tmo_cpu_reset", cpu_reset, 1'b1);
    chk("tmo_busy", busy, 1'b0);
    chk("tmo_nwrites", log_addr.size(), 0);
    $display("txn: timeout abort");

    // recovery load after the error
    clear_log();
    start_load();
    send(8'h00, 0); send(8'h01, 0);
    send(8'hAA, 0); send(8'hBB, 0); send(8'hCC, 0); send(8'hDD, 0);
    in_valid = 1'b0;
    tick(2);
    chk("rec_nwrites", log_addr.size(), 1);
    check_write(0, 4'd0, 32'hAABBCCDD);
    chk("rec_done", done, 1'b1);
    chk("rec_error", error, 1'b0);
    $display("txn: recovery load complete");

    // largest legal program: N = 2^AW words
    clear_log();
    start_load();
    send(8'h00, 0);
    send(8'h10, 0);
    for (int w = 0; w < 16; w++) begin
      wv = 32'h11223300 | 32'(w);
      send(wv[31:24], 0); send(wv[23:16], 0); send(wv[15:8], 0); send(wv[7:0], w % 3);
    end
    in_valid = 1'b0;
    tick(2);
    chk("full_nwrites", log_addr.size(), 16);
    check_write(0,  4'd0,  32'h11223300);
    check_write(15, 4'd15, 32'h1122330F);
    chk("full_done", done, 1'b1);
    chk("full_word_count", word_count, 16);
    $display("txn: full-memory load complete");

    // N = 2^AW + 1 is rejected
    clear_log();
    start_load();
    send(8'h00, 0);
    send(8'h11, 0);
    in_valid = 1'b0;
    chk("len_error", error, 1'b1);
    chk("len_cpu_reset", cpu_reset, 1'b1);
    tick(3);
    chk("len_nwrites", log_addr.size(), 0);
    $display("txn: oversize length rejected");

    // start while busy is ignored; reset mid-word discards the partial word
    clear_log();
    start_load();
    send(8'h00, 0); send(8'h01, 0); send(8'h11, 0);
    in_valid = 1'b0;
    start_load();
    chk("busy_start_ignored", busy, 1'b1);
    send(8'h22, 0);
    in_valid = 1'b0;
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("mid_busy", busy, 1'b0);
    chk("mid_word_count", word_count, 0);
    chk("mid_cpu_reset", cpu_reset, 1'b1);
    chk("mid_in_ready", in_ready, 1'b0);
    tick(3);
    chk("mid_nwrites", log_addr.size(), 0);
    $display("txn: reset mid-load");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
